// File: rtl/updown_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : updown_counter_if
//  Brief    : Control/status bundle for updown_counter (enable, direction,
//             load strobe and value in; count and terminal-count out).
//  Revision : 1.0  initial release
// ============================================================================
interface updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;

    modport master (
        output en,
        output up,
        output load,
        output load_val,
        input  q,
        input  tc
    );

    modport slave (
        input  en,
        input  up,
        input  load,
        input  load_val,
        output q,
        output tc
    );
endinterface
`default_nettype wire

// File: rtl/updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : updown_counter
//  Brief    : Prescaled up/down counter over 0..MAX_COUNT with load and a
//             registered terminal-count pulse. Define UPDOWN_COUNTER_SAT_EN
//             for saturating bounds instead of wrap-around.
//  Revision : 1.0  initial release
// ============================================================================
module updown_counter #(
    parameter int          WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int          PRESCALE  = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    updown_counter_if.slave   bus
);
    localparam int               c_ps_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] c_max     = WIDTH'(MAX_COUNT);
    localparam logic [c_ps_w-1:0] c_ps_last = c_ps_w'(PRESCALE - 1);

    logic [WIDTH-1:0]  count_q, count_d;
    logic [c_ps_w-1:0] ps_q, ps_d;
    logic              tc_q, tc_d;
    logic              w_step;

    always_comb begin
        w_step  = bus.en && (ps_q == c_ps_last);
        count_d = count_q;
        ps_d    = ps_q;
        tc_d    = 1'b0;

        if (bus.load) begin
            count_d = (bus.load_val > c_max) ? c_max : bus.load_val;
            ps_d    = '0;
        end else if (bus.en) begin
            if (!w_step) begin
                ps_d = ps_q + c_ps_w'(1);
            end else begin
                ps_d = '0;
                if (bus.up) begin
                    if (count_q == c_max) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                        count_d = c_max;
`else
                        count_d = '0;
`endif
                        tc_d = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
`ifdef UPDOWN_COUNTER_SAT_EN
                        tc_d = (count_q == c_max - WIDTH'(1));
`endif
                    end
                end else begin
                    if (count_q == '0) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                        count_d = '0;
`else
                        count_d = c_max;
`endif
                        tc_d = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
`ifdef UPDOWN_COUNTER_SAT_EN
                        tc_d = (count_q == WIDTH'(1));
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ps_q    <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            ps_q    <= ps_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.q  = count_q;
    assign bus.tc = tc_q;
endmodule
`default_nettype wire
